// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the CPU instruction/data request ports and the shared memory port
//   slave  : arbiter side (takes requests and mem_readdata, drives responses and mem_* commands)
//   master : environment side (the CPU ports plus the RAM model)
interface mem_port_arbiter_if;
    logic        instr_read;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        instr_valid;
    logic        instr_busy;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic [31:0] data_readdata;
    logic        data_valid;
    logic        data_busy;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    modport slave (
        input  instr_read, instr_address, data_read, data_write, data_address,
               data_writedata, data_byteenable, mem_readdata,
        output instr_readdata, instr_valid, instr_busy, data_readdata, data_valid,
               data_busy, mem_address, mem_read, mem_write, mem_writedata, mem_byteenable
    );
    modport master (
        output instr_read, instr_address, data_read, data_write, data_address,
               data_writedata, data_byteenable, mem_readdata,
        input  instr_readdata, instr_valid, instr_busy, data_readdata, data_valid,
               data_busy, mem_address, mem_read, mem_write, mem_writedata, mem_byteenable
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported RAM between instruction fetch and data ports
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   bus (slave)  : instr_* / data_* request ports and the mem_* RAM port
//   conflict_err : sticky, set when a data request arrives with read and write both high
//   MEM_LATENCY  : cycles from mem_read to valid mem_readdata (1..15)
//   STARVE_LIMIT : consecutive data grants tolerated while a fetch waits (1..15)
//   MEM_ARB_RR_EN: when defined, contention alternates between the two ports instead
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                conflict_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t      state, state_n;
    logic        gnt_d, wr, req_i, req_d, take_d, issue, done, ival, dval;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
`ifdef MEM_ARB_RR_EN
    logic        prio_i;
    assign take_d = req_d && !(req_i && prio_i);
`else
    logic [3:0]  starve_cnt;
    assign take_d = req_d && !(req_i && int'(starve_cnt) >= STARVE_LIMIT);
`endif
    assign req_i = bus.instr_read;
    assign req_d = bus.data_read | bus.data_write;
    assign issue = state == ISSUE;
    assign done  = state == WAIT && cnt == 4'd1;
    // A withdrawn request still completes the access but gets no valid pulse
    assign ival  = done && !gnt_d && req_i;
    assign dval  = gnt_d && req_d && (done || (issue && wr));
    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else       state <= state_n;
    always_comb begin
        state_n = (state == IDLE)  ? ((req_i || req_d) ? ISSUE : IDLE) :
                  (state == ISSUE) ? (wr ? IDLE : WAIT) :
                  (state == WAIT && cnt != 4'd1) ? WAIT : IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_d        <= 1'b0;
            wr           <= 1'b0;
            cnt          <= 4'd0;
            addr_q       <= '0;
            conflict_err <= 1'b0;
`ifdef MEM_ARB_RR_EN
            prio_i       <= 1'b1;
`else
            starve_cnt   <= 4'd0;
`endif
        end else begin
            if (state == IDLE && (req_i || req_d)) begin
                gnt_d <= take_d;
                // read+write together is executed as a write
                wr    <= take_d && bus.data_write;
                if (take_d && bus.data_read && bus.data_write) conflict_err <= 1'b1;
`ifdef MEM_ARB_RR_EN
                prio_i <= take_d;
`else
                starve_cnt <= !take_d ? 4'd0 :
                              (req_i && starve_cnt != 4'hF) ? starve_cnt + 4'd1 : starve_cnt;
`endif
            end
            if (issue) begin
                addr_q <= gnt_d ? bus.data_address : bus.instr_address;
                cnt    <= 4'(MEM_LATENCY);
            end else if (state == WAIT) begin
                cnt    <= cnt - 4'd1;
            end
        end
    end
    always_comb begin
        bus.mem_read       = issue && !wr;
        bus.mem_write      = issue && wr;
        bus.mem_address    = issue ? (gnt_d ? bus.data_address : bus.instr_address) :
                             (state == WAIT) ? addr_q : '0;
        bus.mem_writedata  = (issue && wr) ? bus.data_writedata : '0;
        bus.mem_byteenable = issue ? (gnt_d ? bus.data_byteenable : 4'hF) : 4'h0;
        bus.instr_valid    = ival;
        bus.data_valid     = dval;
        bus.instr_readdata = ival ? bus.mem_readdata : '0;
        bus.data_readdata  = (dval && done) ? bus.mem_readdata : '0;
        bus.instr_busy     = req_i && !ival;
        bus.data_busy      = req_d && !dval;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors, corner sequences and a randomized model check of mem_port_arbiter
module tb_mem_port_arbiter;
    typedef struct {
        logic        ir, dr, dw;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic        e_mr, e_mw;
        logic [3:0]  e_be;
        int          e_lat;
        logic        e_conf;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic i_rd, d_rd, d_wr;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0] d_be;
    logic sel = 1'b0;
    logic conf_a, conf_b;
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    mem_port_arbiter_if bus_a();
    mem_port_arbiter_if bus_b();
    assign bus_a.instr_read = i_rd;      assign bus_b.instr_read = i_rd;
    assign bus_a.instr_address = i_addr; assign bus_b.instr_address = i_addr;
    assign bus_a.data_read = d_rd;       assign bus_b.data_read = d_rd;
    assign bus_a.data_write = d_wr;      assign bus_b.data_write = d_wr;
    assign bus_a.data_address = d_addr;  assign bus_b.data_address = d_addr;
    assign bus_a.data_writedata = d_wdata; assign bus_b.data_writedata = d_wdata;
    assign bus_a.data_byteenable = d_be; assign bus_b.data_byteenable = d_be;
    assign bus_a.mem_readdata = mem_word(bus_a.mem_address);
    assign bus_b.mem_readdata = mem_word(bus_b.mem_address);

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .conflict_err(conf_a));
    mem_port_arbiter #(.MEM_LATENCY(4), .STARVE_LIMIT(4)) u_dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .conflict_err(conf_b));

    logic [31:0] o_ird, o_drd, o_addr, o_wd;
    logic [3:0] o_be;
    logic o_iv, o_ib, o_dv, o_db, o_mr, o_mw, o_conf;
    assign o_ird  = sel ? bus_b.instr_readdata : bus_a.instr_readdata;
    assign o_drd  = sel ? bus_b.data_readdata  : bus_a.data_readdata;
    assign o_addr = sel ? bus_b.mem_address    : bus_a.mem_address;
    assign o_wd   = sel ? bus_b.mem_writedata  : bus_a.mem_writedata;
    assign o_be   = sel ? bus_b.mem_byteenable : bus_a.mem_byteenable;
    assign o_iv   = sel ? bus_b.instr_valid    : bus_a.instr_valid;
    assign o_ib   = sel ? bus_b.instr_busy     : bus_a.instr_busy;
    assign o_dv   = sel ? bus_b.data_valid     : bus_a.data_valid;
    assign o_db   = sel ? bus_b.data_busy      : bus_a.data_busy;
    assign o_mr   = sel ? bus_b.mem_read       : bus_a.mem_read;
    assign o_mw   = sel ? bus_b.mem_write      : bus_a.mem_write;
    assign o_conf = sel ? conf_b               : conf_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rst();
        cyc();
        reset = 1'b1;
        i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Issues one request into an idle arbiter and observes it until its valid pulse
    task automatic access(input vec_t v, output int lat, output logic mr, output logic mw,
                          output logic [31:0] ad, output logic [31:0] wd, output logic [3:0] be,
                          output logic [31:0] rd);
        i_rd = v.ir; i_addr = v.addr;
        d_rd = v.dr; d_wr = v.dw; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
        lat = 0; mr = 0; mw = 0; ad = 0; wd = 0; be = 0; rd = 0;
        for (int n = 1; n <= 30; n++) begin
            #3;
            if (o_mr || o_mw) begin mr = o_mr; mw = o_mw; ad = o_addr; wd = o_wd; be = o_be; end
            if (o_iv || o_dv) begin lat = n; rd = v.ir ? o_ird : o_drd; end
            cyc();
            if (lat != 0) break;
        end
        i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        cyc();
    endtask

    // Transaction-level reference: each access occupies issue + latency, then one idle cycle
    task automatic rand_run(input int lat, input int ncyc);
        int next_free = 0, issue_at = -1, done_at = -1, starve = 0;
        bit busy_m = 0, side_d = 0, m_wr = 0, prio_i = 1, i_act = 0, d_act = 0, drop_i, drop_d;
        bit e_mr, e_mw, e_iv, e_dv;
        logic [31:0] m_addr = 0, m_wd = 0;
        logic [3:0] m_be = 0;
        for (int t = 0; t < ncyc; t++) begin
            if (!i_act && $urandom_range(2) == 0) begin
                i_act = 1; i_rd = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_act && $urandom_range(2) == 0) begin
                d_act = 1; d_wr = 1'($urandom_range(1)); d_rd = ~d_wr;
                d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom_range(15));
            end
            if (!busy_m && t >= next_free && (i_act || d_act)) begin
`ifdef MEM_ARB_RR_EN
                side_d = d_act && !(i_act && prio_i);
                prio_i = side_d;
`else
                side_d = d_act && !(i_act && starve >= 4);
                starve = !side_d ? 0 : (i_act ? starve + 1 : starve);
`endif
                m_wr = side_d && d_wr;
                m_addr = side_d ? d_addr : i_addr;
                m_wd = d_wdata;
                m_be = side_d ? d_be : 4'hF;
                issue_at = t + 1;
                done_at = m_wr ? t + 1 : t + 1 + lat;
                busy_m = 1;
            end
            e_mr = busy_m && t == issue_at && !m_wr;
            e_mw = busy_m && t == issue_at && m_wr;
            e_iv = busy_m && t == done_at && !side_d;
            e_dv = busy_m && t == done_at && side_d;
            #3;
            chk("rnd_mem_read", o_mr, e_mr);
            chk("rnd_mem_write", o_mw, e_mw);
            chk("rnd_instr_valid", o_iv, e_iv);
            chk("rnd_data_valid", o_dv, e_dv);
            chk("rnd_instr_busy", o_ib, i_rd && !e_iv);
            chk("rnd_data_busy", o_db, (d_rd || d_wr) && !e_dv);
            if (e_mr || e_mw) begin
                chk("rnd_issue_addr", o_addr, m_addr);
                chk("rnd_issue_be", o_be, m_be);
                if (m_wr) chk("rnd_wdata", o_wd, m_wd);
            end
            if (busy_m && t > issue_at) chk("rnd_addr_hold", o_addr, m_addr);
            if (e_iv) chk("rnd_instr_rdata", o_ird, mem_word(m_addr));
            else chk("rnd_instr_rdata_zero", o_ird, 0);
            if (e_dv && !m_wr) chk("rnd_data_rdata", o_drd, mem_word(m_addr));
            drop_i = 0; drop_d = 0;
            if (busy_m && t == done_at) begin
                busy_m = 0;
                next_free = t + 1;
                if (side_d) drop_d = 1; else drop_i = 1;
            end
            cyc();
            if (drop_i) begin i_act = 0; i_rd = 1'b0; end
            if (drop_d) begin d_act = 0; d_rd = 1'b0; d_wr = 1'b0; end
        end
        i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        repeat (lat + 4) cyc();
    endtask

    initial begin
        vec_t tbl[7];
        vec_t v;
        int lat, ng, run, maxrun;
        logic mr, mw, anyv;
        logic [31:0] ad, wd, rd;
        logic [3:0] be;
        logic [9:0] g;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'hBFC0_0000, 32'h0,         4'h0, 1'b1, 1'b0, 4'hF, 3, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'h3, 1'b0, 1'b1, 4'h3, 2, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0,         4'hC, 1'b1, 1'b0, 4'hC, 3, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 1'b1, 1'b0, 4'hF, 3, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 4'hF, 2, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h5, 1'b0, 1'b1, 4'h5, 2, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_0030, 32'h0,         4'hF, 1'b1, 1'b0, 4'hF, 3, 1'b1};

        reset = 1'b1; i_rd = 1'b1; d_rd = 1'b0; d_wr = 1'b0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_mem_read", o_mr, 0);
        chk("rst_mem_write", o_mw, 0);
        chk("rst_mem_address", o_addr, 0);
        chk("rst_mem_writedata", o_wd, 0);
        chk("rst_mem_byteenable", o_be, 0);
        chk("rst_instr_valid", o_iv, 0);
        chk("rst_data_valid", o_dv, 0);
        chk("rst_conflict_err", o_conf, 0);
        chk("rst_instr_busy_follows", o_ib, 1);
        chk("rst_data_busy_follows", o_db, 0);
        i_rd = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();

        for (int k = 0; k < 7; k++) begin
            access(tbl[k], lat, mr, mw, ad, wd, be, rd);
            chk($sformatf("tbl%0d_mem_read", k), mr, tbl[k].e_mr);
            chk($sformatf("tbl%0d_mem_write", k), mw, tbl[k].e_mw);
            chk($sformatf("tbl%0d_mem_address", k), ad, tbl[k].addr);
            chk($sformatf("tbl%0d_mem_byteenable", k), be, tbl[k].e_be);
            chk($sformatf("tbl%0d_latency", k), 32'(lat), 32'(tbl[k].e_lat));
            if (tbl[k].e_mw) chk($sformatf("tbl%0d_mem_writedata", k), wd, tbl[k].wdata);
            if (tbl[k].e_mr) chk($sformatf("tbl%0d_readdata", k), rd, mem_word(tbl[k].addr));
            chk($sformatf("tbl%0d_conflict_err", k), o_conf, tbl[k].e_conf);
        end
        rst();
        #3;
        chk("conflict_cleared_by_reset", o_conf, 0);
        cyc();

        rst();
        i_rd = 1'b1; i_addr = 32'h100; d_rd = 1'b1; d_addr = 32'h200; d_be = 4'hF;
        g = 0; ng = 0; run = 0; maxrun = 0;
        for (int c = 0; c < 300 && ng < 10; c++) begin
            #3;
            if (o_mr) begin g[ng] = (o_addr == 32'h100); ng++; end
            run = o_ib ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            cyc();
        end
        chk("contention_grants", ng, 10);
`ifdef MEM_ARB_RR_EN
        chk("contention_order", 32'(g), 32'h155);
`else
        chk("contention_order", 32'(g), 32'h210);
`endif
        chk("contention_instr_busy_bound", maxrun <= 4 * (1 + 2) + 1 + 2, 1);
        i_rd = 1'b0; d_rd = 1'b0;
        repeat (5) cyc();

        sel = 1'b1;
        rst();
        i_rd = 1'b1; i_addr = 32'h300; anyv = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            #3;
            anyv |= o_iv;
            cyc();
        end
        reset = 1'b1;
        #3;
        anyv |= o_iv;
        cyc();
        #3;
        anyv |= o_iv;
        chk("rstwait_no_valid", anyv, 0);
        chk("rstwait_mem_read", o_mr, 0);
        chk("rstwait_mem_write", o_mw, 0);
        chk("rstwait_mem_address", o_addr, 0);
        chk("rstwait_mem_byteenable", o_be, 0);
        chk("rstwait_mem_writedata", o_wd, 0);
        chk("rstwait_instr_busy", o_ib, 1);
        cyc();
        reset = 1'b0;
        v = '{1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 1'b1, 1'b0, 4'hF, 6, 1'b0};
        access(v, lat, mr, mw, ad, wd, be, rd);
        chk("refetch_latency", 32'(lat), 32'(v.e_lat));
        chk("refetch_mem_read", mr, 1);
        chk("refetch_mem_address", ad, 32'h300);
        chk("refetch_readdata", rd, mem_word(32'h300));

        sel = 1'b0;
        rst();
        rand_run(1, 400);
        sel = 1'b1;
        rst();
        rand_run(4, 400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
